// File: rtl/uart_pkg.sv
// Shared UART definitions: Tx FSM states, serial line levels and parity.
// Imported by both the transmitter and the receiver so bit order and levels agree.
package uart_pkg;

    // Widest payload the parity helper accepts; narrower data is zero-extended.
    localparam int UART_MAX_BITS = 32;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    // Zero padding does not change the XOR, so one helper serves any width.
    function automatic logic uart_parity(
        input logic [UART_MAX_BITS-1:0] data,
        input logic                     odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: counts clk cycles within one serial bit while run=1.
// Ports: clk, rst_n (async low), run (hold at 0 when idle), bit_end (last tick of a bit).
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_end
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    logic [TW-1:0] tick;

    assign bit_end = run && (tick == LAST);

    // Wrap at every bit boundary so each bit starts at tick 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= '0;
        end else if (!run || bit_end) begin
            tick <= '0;
        end else begin
            tick <= tick + TW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_piso.sv
// UART transmitter: frames one byte as start, data MSB first, optional parity, stop.
// Ports: Tx_clk, rst_n, tx_start, data_in -> tx (serial), tx_busy, tx_done (1-cycle pulse).
module uart_tx_piso
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 Tx_clk,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(DATA_BITS - 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] sh_next;
    logic [BW-1:0]        bit_idx;
    logic                 par_bit;
    logic                 bit_end;
    logic                 run;

    assign run     = (state != TX_IDLE);
    assign sh_next = shreg << 1;

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_timer (
        .clk    (Tx_clk),
        .rst_n  (rst_n),
        .run    (run),
        .bit_end(bit_end)
    );

    // tx is registered, so each branch loads the level of the bit that
    // starts on the following cycle.
    always_ff @(posedge Tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            par_bit <= 1'b0;
            tx      <= UART_IDLE_LVL;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                TX_IDLE: begin
                    tx      <= UART_IDLE_LVL;
                    tx_busy <= 1'b0;
                    if (tx_start) begin
                        shreg   <= data_in;
                        par_bit <= uart_parity(UART_MAX_BITS'(data_in),
                                               PARITY_ODD != 0);
                        bit_idx <= '0;
                        tx      <= UART_START_LVL;
                        tx_busy <= 1'b1;
                        state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        tx    <= shreg[DATA_BITS-1];
                        state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        shreg   <= sh_next;
                        bit_idx <= bit_idx + BW'(1);
                        if (bit_idx == LAST_IDX) begin
                            if (PARITY_EN != 0) begin
                                tx    <= par_bit;
                                state <= TX_PARITY;
                            end else begin
                                tx    <= UART_STOP_LVL;
                                state <= TX_STOP;
                            end
                        end else begin
                            tx <= sh_next[DATA_BITS-1];
                        end
                    end
                end
                TX_PARITY: begin
                    if (bit_end) begin
                        tx    <= UART_STOP_LVL;
                        state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        tx      <= UART_IDLE_LVL;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                        state   <= TX_IDLE;
                    end
                end
                default: begin
                    tx      <= UART_IDLE_LVL;
                    tx_busy <= 1'b0;
                    state   <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_piso.md
Name: uart_tx_piso

Overview:
- Parallel-in/serial-out UART transmitter. Frames one byte per request as start, data (MSB first), optional parity, stop.
- Sits in the Tx path, driven by a 16x-oversampled baud clock.
- Holds each serial bit for OVERSAMPLE clock cycles, matching the Rx path's sampling rate and bit order.

Parameters:
- DATA_BITS, 8, number of payload bits per frame.
- OVERSAMPLE, 16, Tx_clk cycles per serial bit.
- PARITY_EN, 1, 1 = insert parity bit after data; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).

Ports:
- Tx_clk  input  1  oversampled baud clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_start  input  1  request to send data_in; sampled only in IDLE.
- data_in  input  DATA_BITS  byte to transmit; captured on the accept cycle.
- tx  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is in flight.
- tx_done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. rst_n=0 forces the following immediately, regardless of state, including mid-frame:
  - tx=1, tx_busy=0, tx_done=0
  - state=IDLE, counters=0, shift register=0
- All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If tx_start=1, latch data_in into the shift register, compute parity, and go to START next cycle.
  - tx_busy rises in the same edge as the START entry.
- START:
  - tx=0 for OVERSAMPLE cycles; tick counter runs 0..OVERSAMPLE-1.
  - At tick OVERSAMPLE-1, go to DATA.
- DATA:
  - tx = shift register MSB.
  - At tick OVERSAMPLE-1: shift left by one, increment the bit index.
  - After DATA_BITS bits, go to PARITY if PARITY_EN, else STOP.
- PARITY:
  - tx = XOR of latched data, XOR PARITY_ODD, for OVERSAMPLE cycles; then go to STOP.
- STOP:
  - tx=1 for OVERSAMPLE cycles.
  - At tick OVERSAMPLE-1: go to IDLE, tx_busy falls, tx_done=1 for exactly that one following cycle.
- Frame length: (2 + DATA_BITS + PARITY_EN) * OVERSAMPLE cycles of tx_busy. Default is 176.
- Latency: first start-bit cycle on tx appears 1 cycle after the accepting edge.
- tx_start while busy: ignored and not queued. data_in changes mid-frame have no effect.
- Back-to-back: tx_start held high re-accepts in the first IDLE cycle. Minimum inter-frame gap is 1 cycle of tx=1 beyond the stop bit.
- Counter widths:
  - tick counter: $clog2(OVERSAMPLE) bits, wraps to 0 at every bit boundary.
  - bit index: $clog2(DATA_BITS+1) bits, cleared on entry to START.
- Illegal state encoding: return to IDLE with tx=1.

Decomposition:
- Shared package uart_pkg:
  - tx state enum (IDLE, START, DATA, PARITY, STOP)
  - line-level constants UART_IDLE_LVL=1, UART_START_LVL=0, UART_STOP_LVL=1
  - pure function uart_parity(data, odd)
- The Rx side reuses the same package.
- Optional single sub-module uart_bit_timer: OVERSAMPLE tick counter with a bit_end strobe. Shareable with the receiver; inline implementation is acceptable.

Test Plan:
- Reset, then idle 50 cycles -> tx=1, tx_busy=0, tx_done=0 throughout.
- data_in=0xA5, tx_start for 1 cycle, defaults -> tx sequence, each bit held 16 cycles:
  - 0, then 1,0,1,0,0,1,0,1, parity 0, stop 1
  - tx_busy high 176 cycles
  - tx_done single pulse at the end
- PARITY_ODD=1, data_in=0x07 -> parity bit 0. PARITY_EN=0, data_in=0x07 -> frame is 160 cycles with no parity slot.
- tx_start held high with data_in=0xFF then 0x00:
  - first frame 0xFF, parity 0
  - exactly 1 idle-high cycle
  - second frame 0x00, parity 0
  - tx_start pulses and data_in changes during the frames are ignored.
- Assert rst_n=0 at cycle 70 of a 0x3C frame -> tx=1 and tx_busy=0 immediately (same cycle, asynchronous). After release, a new 0x81 frame transmits correctly from a clean start bit.
- Random 200 bytes, random parity params -> a scoreboard samples tx at mid-bit (tick 7) and reconstructs data and parity with zero mismatches.
